rc_burst_sequencer: RTL and testbench

//  Sequences single and burst transfers between the UART gateway and the ring controller (RC), one 32-bit word at a time.

---
 rtl/rc_burst_sequencer.sv | 163 ++++++++++++++++
 tb/tb_rc_burst_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_burst_sequencer.sv
// Word-at-a-time single/burst transfer sequencer between the UART
// gateway and the ring controller request/response pins.
module rc_burst_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int W_TIMEOUT = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        is_write,
  input  logic [31:0] base_addr,
  input  logic [31:0] word_count,
  input  logic        abort,
  input  logic [31:0] wr_word,
  input  logic        wr_word_valid,
  output logic        wr_word_ready,
  output logic [31:0] rd_word,
  output logic        rd_word_valid,
  input  logic        rd_word_ready,
  output logic [31:0] address,
  output logic [31:0] data_out,
  output logic        write_transfer_valid,
  input  logic        write_resp_valid,
  output logic        read_transfer_valid,
  input  logic        read_resp_valid,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_done
);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_WDATA,
    ISSUE_WR,
    WAIT_WR_RESP,
    ISSUE_RD,
    WAIT_RD_RESP,
    PUSH_RDATA,
    DONE,
    ERROR
  } state_t;

  state_t state_q, state_d;

  logic [31:0]          base_q;
  logic [31:0]          count_q;
  logic [31:0]          index_q;
  logic [W_TIMEOUT-1:0] timer_q;

  logic load_cmd;
  logic advance;
  logic take_wr;
  logic take_rd;
  logic last;
  logic expired;

  assign last    = (index_q + 32'd1) == count_q;
  assign expired = timer_q == W_TIMEOUT'(TIMEOUT_CYCLES - 1);

  // abort overrides every other event, including a same-cycle response
  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    advance  = 1'b0;
    take_wr  = 1'b0;
    take_rd  = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            load_cmd = 1'b1;
            if (word_count == 32'd0)
              state_d = DONE;
            else if (is_write)
              state_d = WAIT_WDATA;
            else
              state_d = ISSUE_RD;
          end
        end
        WAIT_WDATA: begin
          if (wr_word_valid) begin
            take_wr = 1'b1;
            state_d = ISSUE_WR;
          end
        end
        ISSUE_WR: state_d = WAIT_WR_RESP;
        WAIT_WR_RESP: begin
          if (write_resp_valid) begin
            advance = 1'b1;
            state_d = last ? DONE : WAIT_WDATA;
          end else if (expired) begin
            state_d = ERROR;
          end
        end
        ISSUE_RD: state_d = WAIT_RD_RESP;
        WAIT_RD_RESP: begin
          if (read_resp_valid) begin
            take_rd = 1'b1;
            state_d = PUSH_RDATA;
          end else if (expired) begin
            state_d = ERROR;
          end
        end
        PUSH_RDATA: begin
          if (rd_word_ready) begin
            advance = 1'b1;
            state_d = last ? DONE : ISSUE_RD;
          end
        end
        DONE:    state_d = IDLE;
        ERROR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      index_q  <= '0;
      timer_q  <= '0;
      data_out <= '0;
      rd_word  <= '0;
    end else begin
      state_q <= state_d;
      if (load_cmd) begin
        base_q  <= base_addr;
        count_q <= word_count;
        index_q <= '0;
      end
      if (advance)
        index_q <= index_q + 32'd1;
      if (take_wr)
        data_out <= wr_word;
      if (take_rd)
        rd_word <= data_in;
      if (state_q == ISSUE_WR || state_q == ISSUE_RD)
        timer_q <= '0;
      else if (state_q == WAIT_WR_RESP ||
               state_q == WAIT_RD_RESP)
        timer_q <= timer_q + 1'b1;
    end
  end

  // index and completed-word count advance together
  assign words_done = index_q;
  assign address    = base_q + {index_q[29:0], 2'b00};

  assign wr_word_ready        = state_q == WAIT_WDATA;
  assign write_transfer_valid = state_q == ISSUE_WR;
  assign read_transfer_valid  = state_q == ISSUE_RD;
  assign rd_word_valid        = state_q == PUSH_RDATA;
  assign busy                 = state_q != IDLE;
  assign done                 = state_q == DONE;
  assign error                = state_q == ERROR;

endmodule

// File: tb/tb_rc_burst_sequencer.sv
// Self-checking bench for rc_burst_sequencer: directed table,
// multi-cycle corner sequences and randomized bursts.
module tb_rc_burst_sequencer;

  localparam int TC = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        is_write;
  logic [31:0] base_addr;
  logic [31:0] word_count;
  logic        abort;
  logic [31:0] wr_word;
  logic        wr_word_valid;
  logic        wr_word_ready;
  logic [31:0] rd_word;
  logic        rd_word_valid;
  logic        rd_word_ready;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        write_transfer_valid;
  logic        write_resp_valid;
  logic        read_transfer_valid;
  logic        read_resp_valid;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] words_done;

  always #5 clk = ~clk;

  rc_burst_sequencer #(.TIMEOUT_CYCLES(TC)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .start                (start),
    .is_write             (is_write),
    .base_addr            (base_addr),
    .word_count           (word_count),
    .abort                (abort),
    .wr_word              (wr_word),
    .wr_word_valid        (wr_word_valid),
    .wr_word_ready        (wr_word_ready),
    .rd_word              (rd_word),
    .rd_word_valid        (rd_word_valid),
    .rd_word_ready        (rd_word_ready),
    .address              (address),
    .data_out             (data_out),
    .write_transfer_valid (write_transfer_valid),
    .write_resp_valid     (write_resp_valid),
    .read_transfer_valid  (read_transfer_valid),
    .read_resp_valid      (read_resp_valid),
    .data_in              (data_in),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .words_done           (words_done)
  );

  int passed = 0;
  int total  = 0;
  int done_cnt;
  int err_cnt;
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic [31:0] rq_a[$];
  logic [31:0] dat[8];

  typedef struct {
    logic        w;
    logic [31:0] base;
    logic [31:0] cnt;
    logic [31:0] last_a;
  } vec_t;

  vec_t tbl[6];

  // RC-side observer: records every request and status pulse
  always @(negedge clk) begin
    if (rstn) begin
      if (write_transfer_valid) begin
        wq_a.push_back(address);
        wq_d.push_back(data_out);
      end
      if (read_transfer_valid)
        rq_a.push_back(address);
      if (done)
        done_cnt++;
      if (error)
        err_cnt++;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq_a.delete();
    wq_d.delete();
    rq_a.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic run_burst(input logic w,
                           input logic [31:0] base,
                           input logic [31:0] cnt,
                           input int max_dly,
                           input int max_stall,
                           input int stall_idx,
                           input int stall_len,
                           output logic [31:0] last_a);
    logic [31:0] ea;
    int k;
    int d;
    int s;
    int np;
    int no;
    clear_mon();
    start      = 1'b1;
    is_write   = w;
    base_addr  = base;
    word_count = cnt;
    step();
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = $urandom;
    is_write   = $urandom_range(0, 1);
    for (int i = 0; i < int'(cnt); i++) begin
      ea = base + 32'(i * 4);
      if (w) begin
        d = $urandom_range(0, 2);
        for (int j = 0; j < d; j++) begin
          read_resp_valid = $urandom_range(0, 1);
          step();
        end
        read_resp_valid = 1'b0;
        wr_word       = dat[i];
        wr_word_valid = 1'b1;
        k = 0;
        while (!wr_word_ready && k < 20) begin
          step();
          k++;
        end
        chk("wr_ready", {31'd0, wr_word_ready}, 32'd1);
        step();
        wr_word_valid = 1'b0;
        wr_word       = $urandom;
        chk("wr_pulse", {31'd0, write_transfer_valid}, 32'd1);
        chk("wr_addr", address, ea);
        chk("wr_data", data_out, dat[i]);
        step();
        repeat ($urandom_range(0, max_dly)) step();
        write_resp_valid = 1'b1;
        step();
        write_resp_valid = 1'b0;
      end else begin
        chk("rd_pulse", {31'd0, read_transfer_valid}, 32'd1);
        chk("rd_addr", address, ea);
        step();
        d = $urandom_range(0, max_dly);
        for (int j = 0; j < d; j++) begin
          start      = $urandom_range(0, 1);
          base_addr  = $urandom;
          word_count = $urandom;
          step();
        end
        start           = 1'b0;
        read_resp_valid = 1'b1;
        data_in         = dat[i];
        step();
        read_resp_valid = 1'b0;
        data_in         = $urandom;
        chk("rd_valid", {31'd0, rd_word_valid}, 32'd1);
        chk("rd_word", rd_word, dat[i]);
        s = (i == stall_idx) ? stall_len
                             : $urandom_range(0, max_stall);
        for (int j = 0; j < s; j++) begin
          step();
          chk("stall_no_req",
              {31'd0, read_transfer_valid}, 32'd0);
          chk("stall_hold", rd_word, dat[i]);
        end
        rd_word_ready = 1'b1;
        step();
        rd_word_ready = 1'b0;
      end
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("words_done", words_done, cnt);
    step();
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("done_1cyc", {31'd0, done}, 32'd0);
    np = w ? wq_a.size() : rq_a.size();
    no = w ? rq_a.size() : wq_a.size();
    chk("pulse_cnt", 32'(np), cnt);
    chk("other_pulses", 32'(no), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("err_cnt", 32'(err_cnt), 32'd0);
    last_a = 32'd0;
    for (int i = 0; i < np; i++) begin
      ea = base + 32'(i * 4);
      last_a = w ? wq_a[i] : rq_a[i];
      chk("seq_addr", last_a, ea);
      if (w)
        chk("seq_data", wq_d[i], dat[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] la;
    logic [31:0] b;
    logic        w;
    int k;

    tbl[0] = '{1'b1, 32'h0000_0100, 32'd1, 32'h0000_0100};
    tbl[1] = '{1'b0, 32'h0000_0200, 32'd3, 32'h0000_0208};
    tbl[2] = '{1'b1, 32'hFFFF_FFFC, 32'd2, 32'h0000_0000};
    tbl[3] = '{1'b0, 32'hFFFF_FFF8, 32'd3, 32'h0000_0000};
    tbl[4] = '{1'b0, 32'h0000_0040, 32'd0, 32'h0000_0000};
    tbl[5] = '{1'b1, 32'h7FFF_FFFC, 32'd2, 32'h8000_0000};

    rstn             = 1'b0;
    start            = 1'b0;
    is_write         = 1'b0;
    base_addr        = '0;
    word_count       = '0;
    abort            = 1'b0;
    wr_word          = '0;
    wr_word_valid    = 1'b0;
    rd_word_ready    = 1'b0;
    write_resp_valid = 1'b0;
    read_resp_valid  = 1'b0;
    data_in          = '0;
    clear_mon();
    repeat (3) step();
    rstn = 1'b1;
    step();

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_rdword", rd_word, 32'd0);
    chk("rst_wdone", words_done, 32'd0);
    chk("rst_flags",
        {26'd0, wr_word_ready, rd_word_valid,
         write_transfer_valid, read_transfer_valid,
         done, error}, 32'd0);

    // directed table: single write, read burst with stall, wraps, count 0
    foreach (tbl[i]) begin
      dat[0] = tbl[i].w ? 32'hDEAD_BEEF : 32'h11;
      dat[1] = 32'h22;
      dat[2] = 32'h33;
      run_burst(tbl[i].w, tbl[i].base, tbl[i].cnt,
                0, 0, 1, 5, la);
      chk("last_addr", la, tbl[i].last_a);
    end

    // timeout with silent RC
    clear_mon();
    start = 1'b1; is_write = 1'b0;
    base_addr = 32'h300; word_count = 32'd1;
    step();
    start = 1'b0;
    chk("to_pulse", {31'd0, read_transfer_valid}, 32'd1);
    step();
    k = 0;
    while (!error && k < TC + 5) begin
      step();
      k++;
    end
    chk("to_cycles", 32'(k), 32'(TC));
    step();
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);
    chk("to_no_done", 32'(done_cnt), 32'd0);

    // response in the expiry cycle wins
    clear_mon();
    start = 1'b1; is_write = 1'b0;
    base_addr = 32'h300; word_count = 32'd1;
    step();
    start = 1'b0;
    step();
    repeat (TC - 1) step();
    read_resp_valid = 1'b1;
    data_in = 32'h55;
    step();
    read_resp_valid = 1'b0;
    chk("exp_no_err", {31'd0, error}, 32'd0);
    chk("exp_valid", {31'd0, rd_word_valid}, 32'd1);
    chk("exp_word", rd_word, 32'h55);
    rd_word_ready = 1'b1;
    step();
    rd_word_ready = 1'b0;
    chk("exp_done", {31'd0, done}, 32'd1);
    step();
    chk("exp_err_cnt", 32'(err_cnt), 32'd0);

    // abort against a same-cycle write response
    clear_mon();
    start = 1'b1; is_write = 1'b1;
    base_addr = 32'h500; word_count = 32'd2;
    step();
    start = 1'b0;
    wr_word = 32'hA5A5_A5A5;
    wr_word_valid = 1'b1;
    step();
    wr_word_valid = 1'b0;
    step();
    abort = 1'b1;
    write_resp_valid = 1'b1;
    step();
    abort = 1'b0;
    write_resp_valid = 1'b0;
    chk("ab_idle", {31'd0, busy}, 32'd0);
    chk("ab_no_done", {31'd0, done}, 32'd0);
    chk("ab_wdone", words_done, 32'd0);
    repeat (3) step();
    chk("ab_done_cnt", 32'(done_cnt), 32'd0);
    chk("ab_err_cnt", 32'(err_cnt), 32'd0);

    // reset while holding read data for the gateway
    clear_mon();
    start = 1'b1; is_write = 1'b0;
    base_addr = 32'h600; word_count = 32'd2;
    step();
    start = 1'b0;
    step();
    read_resp_valid = 1'b1;
    data_in = 32'h77;
    step();
    read_resp_valid = 1'b0;
    chk("rs_pre_valid", {31'd0, rd_word_valid}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rs_valid", {31'd0, rd_word_valid}, 32'd0);
    chk("rs_word", rd_word, 32'd0);
    chk("rs_addr", address, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    step();
    rstn = 1'b1;
    step();
    dat[0] = 32'hCAFE_0001;
    dat[1] = 32'hCAFE_0002;
    run_burst(1'b0, 32'h700, 32'd2, 1, 1, -1, 0, la);
    chk("rs_last", la, 32'h704);

    // randomized bursts
    for (int n = 0; n < 40; n++) begin
      w = $urandom_range(0, 1);
      b = $urandom;
      if ($urandom_range(0, 3) == 0)
        b = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      foreach (dat[i])
        dat[i] = $urandom;
      run_burst(w, b, 32'($urandom_range(0, 5)),
                4, 3, -1, 0, la);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
